// File: rtl/octal_display_scan_pkg.sv
// Shared constants and helpers for the octal display scanner.
// Holds digit geometry, blanking constants and digit-extraction functions.
// Pure declarations; no state, no latency, no flow control.
package octal_display_scan_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 3;
    localparam int PRODUCT_W  = 16;
    localparam int IDX_W      = 3;
    localparam int OCT_W      = NUM_DIGITS * DIGIT_W;

    localparam logic [IDX_W-1:0]      FIRST_SLOT  = 3'd0;
    localparam logic [IDX_W-1:0]      LAST_SLOT   = 3'd5;
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF  = 6'b111111;
    localparam logic [DIGIT_W-1:0]    DIGIT_BLANK = 3'b000;

    // Registered drive for the display: selected digit plus its enables.
    typedef struct packed {
        logic [DIGIT_W-1:0]    digit;
        logic [NUM_DIGITS-1:0] an_n;
    } scan_out_t;

    // Octal digit idx of value; the top digit only carries value[15].
    function automatic logic [DIGIT_W-1:0] octal_digit(
        input logic [PRODUCT_W-1:0] value,
        input logic [IDX_W-1:0]     idx
    );
        logic [OCT_W-1:0] ext;
        ext = {{(OCT_W-PRODUCT_W){1'b0}}, value};
        return ext[idx*DIGIT_W +: DIGIT_W];
    endfunction

    // True when digit idx and every more significant digit are zero.
    function automatic logic upper_zero(
        input logic [PRODUCT_W-1:0] value,
        input logic [IDX_W-1:0]     idx
    );
        logic [OCT_W-1:0] ext;
        ext = {{(OCT_W-PRODUCT_W){1'b0}}, value};
        return (ext >> (idx*DIGIT_W)) == '0;
    endfunction

endpackage

// File: rtl/octal_display_scan_if.sv
// Product strobe in, multiplexed digit drive and pending flag out.
// Wires only; timing is set by the modules on either side.
// No backpressure: product_valid is a one-cycle strobe, never stalled.
interface octal_display_scan_if;
    import octal_display_scan_pkg::*;

    logic                  product_valid;
    logic [PRODUCT_W-1:0]  product;
    logic [DIGIT_W-1:0]    digit;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  pending;

    modport master (
        output product_valid, product,
        input  digit, an_n, pending
    );

    modport slave (
        input  product_valid, product,
        output digit, an_n, pending
    );

endinterface

// File: rtl/octal_display_scan_prescaler.sv
// Free-running refresh prescaler: counts 0..REFRESH_DIV-1 and wraps.
// tick_o is combinational from the count, high in the cycle count = REFRESH_DIV-1.
// No backpressure; runs every cycle out of reset.
module scan_prescaler #(
    parameter int REFRESH_DIV = 50000,
    localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Wrap to zero on the terminal count, otherwise increment.
    always_comb begin
        tick_o  = (count_q == CNT_W'(REFRESH_DIV - 1));
        count_d = tick_o ? '0 : count_q + 1'b1;
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/octal_display_scan.sv
// Scans a 16-bit product onto six multiplexed octal digits with leading-zero blanking.
// digit/an_n are registered, one cycle behind the scan index; new products show from the next frame.
// No backpressure: later strobes overwrite the pending value until the frame-wrap commit.
module octal_display_scan
    import octal_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_BLANK    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    octal_display_scan_if.slave bus
);

    logic                  tick;
    logic                  commit;
    logic                  blank;

    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [PRODUCT_W-1:0]  disp_q,     disp_d;
    logic [PRODUCT_W-1:0]  pend_val_q, pend_val_d;
    logic                  pend_q,     pend_d;
    scan_out_t             out_q,      out_d;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_o  (tick),
        .count_o ()
    );

    // Commit only at the 5->0 wrap so a frame never mixes two products.
    assign commit = tick && (idx_q == LAST_SLOT);

    // Scan index, pending capture and display commit.
    always_comb begin
        idx_d      = idx_q;
        disp_d     = disp_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        if (tick) begin
            idx_d = (idx_q == LAST_SLOT) ? FIRST_SLOT : idx_q + 1'b1;
        end
        if (commit) begin
            // A strobe landing on the commit tick is newer than anything pending.
            if (bus.product_valid) begin
                disp_d = bus.product;
            end else if (pend_q) begin
                disp_d = pend_val_q;
            end
            pend_d = 1'b0;
        end else if (bus.product_valid) begin
            pend_val_d = bus.product;
            pend_d     = 1'b1;
        end
    end

    // Digit select and blanking, looking only at the committed display value.
    always_comb begin
        blank     = (LZ_BLANK != 0) && (idx_q != FIRST_SLOT) && upper_zero(disp_q, idx_q);
        out_d     = '{digit: DIGIT_BLANK, an_n: AN_ALL_OFF};
        if (!blank) begin
            out_d.digit = octal_digit(disp_q, idx_q);
            out_d.an_n  = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    // Scan, capture and output registers; reset drops any pending product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= FIRST_SLOT;
            disp_q     <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            out_q      <= '{digit: DIGIT_BLANK, an_n: AN_ALL_OFF};
        end else begin
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
        end
    end

    assign bus.digit   = out_q.digit;
    assign bus.an_n    = out_q.an_n;
    assign bus.pending = pend_q;

endmodule

// File: tb/tb_octal_display_scan.sv
// Bench for octal_display_scan: blanking and non-blanking instances share stimulus.
// Expected per-slot outputs are queued when stimulus is planned; a monitor
// samples mid-slot (every REFRESH_DIV cycles) and pops/compares.
module tb_octal_display_scan;
    import octal_display_scan_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    typedef struct {
        logic [5:0] an_a;
        logic [2:0] dg_a;
        logic [5:0] an_b;
        logic [2:0] dg_b;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    octal_display_scan_if bus_a ();
    octal_display_scan_if bus_b ();

    octal_display_scan #(.REFRESH_DIV(DIV), .LZ_BLANK(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    octal_display_scan #(.REFRESH_DIV(DIV), .LZ_BLANK(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", nm, act, exp_v, $time, cyc);
    endtask

    // Queue one frame: digs holds slot digits (slot i at bits 3i+2:3i, written
    // as an octal literal), lit = slots lit with blanking, pmask = pending per slot.
    task automatic push_frame(input logic [17:0] digs, input int lit,
                              input logic [5:0] pmask, input int nslots);
        for (int s = 0; s < nslots; s++) begin
            exp_t e;
            e.an_b = ~(6'b000001 << s);
            e.dg_b = digs[3*s +: 3];
            e.an_a = (s < lit) ? e.an_b : 6'b111111;
            e.dg_a = (s < lit) ? e.dg_b : 3'b000;
            e.pend = pmask[s];
            sb.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] p);
        bus_a.product_valid = v;  bus_a.product = p;
        bus_b.product_valid = v;  bus_b.product = p;
    endtask

    // Strobe sampled by the posedge that makes cyc == edge_n.
    task automatic strobe(input int edge_n, input logic [15:0] p);
        while (cyc < edge_n - 1) @(negedge clk);
        drive(1'b1, p);
        @(negedge clk);
        drive(1'b0, 16'h0000);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " digit A"}, bus_a.digit, 0);
        check({tag, " an_n A"},  bus_a.an_n, 6'h3f);
        check({tag, " digit B"}, bus_b.digit, 0);
        check({tag, " an_n B"},  bus_b.an_n, 6'h3f);
        check({tag, " pending"}, bus_a.pending, 0);
    endtask

    // Monitor: mid-slot sample, pop the expected entry and compare.
    always @(negedge clk) begin
        if (rst_n && mon_en && (cyc % DIV == 2)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb underflow: DUT slot at cyc %0d with no expected entry", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("slot an_n A",   bus_a.an_n,    mon_e.an_a);
                check("slot digit A",  bus_a.digit,   mon_e.dg_a);
                check("slot an_n B",   bus_b.an_n,    mon_e.an_b);
                check("slot digit B",  bus_b.digit,   mon_e.dg_b);
                check("slot pending",  bus_a.pending, mon_e.pend);
                check("slot pend B",   bus_b.pending, mon_e.pend);
            end
        end
    end

    initial begin
        drive(1'b0, 16'h0000);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(negedge clk);
        check_reset_state("reset held");

        // Phase A: frame 24 cycles, commit edges at 24, 48, 72, ...
        push_frame(18'o000000, 1, 6'b000000, 6);  // idle zero
        push_frame(18'o000000, 1, 6'b111110, 6);  // FFFF pending from edge 30
        push_frame(18'o177777, 6, 6'b111110, 6);  // FFFF shown; 83 pending
        push_frame(18'o000123, 3, 6'b111110, 6);  // 83 shown; 8 then 9 pending
        push_frame(18'o000011, 2, 6'b000000, 6);  // 9 shown; 7 on commit tick
        push_frame(18'o000007, 1, 6'b000000, 6);  // 7 shown, pending never set
        push_frame(18'o000007, 1, 6'b001110, 4);  // 1234 pending, reset in slot 3
        mon_en = 1'b1;
        rst_n  = 1'b1;

        @(posedge clk);
        #1;
        check("first edge an_n A",  bus_a.an_n, 6'b111110);
        check("first edge digit A", bus_a.digit, 0);
        @(negedge clk);

        strobe(30,  16'hFFFF);
        strobe(52,  16'd83);
        strobe(76,  16'd8);
        strobe(84,  16'd9);
        strobe(120, 16'd7);
        strobe(148, 16'h1234);

        while (cyc < 159) @(negedge clk);
        mon_en = 1'b0;
        check("sb drained A", sb.size(), 0);
        check("pending before reset", bus_a.pending, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid-frame reset");
        repeat (2) @(negedge clk);
        check_reset_state("mid-frame reset held");

        // Phase B: the discarded 1234 must never reach the display.
        push_frame(18'o000000, 1, 6'b000000, 6);
        push_frame(18'o000000, 1, 6'b000000, 6);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("rerelease an_n A",  bus_a.an_n, 6'b111110);
        check("rerelease digit B", bus_b.digit, 0);
        while (cyc < 2*6*DIV - 1) @(negedge clk);
        mon_en = 1'b0;
        check("sb drained B", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/octal_display_scan.md
OCTAL_DISPLAY_SCAN -- requirements
Module: octal_display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000; clk cycles each digit stays lit (legal range 2..2^20).
REQ-002 Parameter LZ_BLANK, default 1; 1 enables leading-zero blanking, 0 always lights all six digits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 product_valid  input  1  one-cycle strobe marking product as a new result.
REQ-006 product  input  16  unsigned 8x8 multiplier result, sampled only when product_valid=1.
REQ-007 digit  output  3  octal digit for the current scan slot; drives the segment decoder's binary input.
REQ-008 an_n  output  6  active-low digit enables, bit i = octal digit i (0 = least significant).
REQ-009 pending  output  1  high while a captured product awaits commit to the display.

Function
REQ-010 The block SHALL split the displayed 16-bit value into six octal digits: digit i = value[3i+2:3i] for i=0..4, and digit 5 = {2'b00, value[15]}.
REQ-011 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap, asserting an internal tick in the cycle the count equals REFRESH_DIV-1.
REQ-012 A scan index SHALL advance 0,1,2,3,4,5,0... on each tick, changing only on tick.
REQ-013 digit and an_n SHALL be registered, reflecting the current scan index one cycle after it changes; exactly one an_n bit is low unless the slot is blanked.
REQ-014 On product_valid=1, product SHALL be captured into a pending register and pending set on the next edge; a later strobe before commit overwrites the pending value (last write wins).
REQ-015 Commit SHALL occur only on the tick where the scan index wraps 5->0: if pending=1, the display register loads the pending value and pending clears, so a frame never mixes old and new digits.
REQ-016 If product_valid coincides with the commit tick, the incoming product SHALL commit directly to the display register and pending SHALL be 0 afterwards.
REQ-017 With LZ_BLANK=1, slot i>0 SHALL be blanked (all an_n high, digit driven 3'b000) when digits i..5 of the display register are all zero; slot 0 is never blanked.
REQ-018 With LZ_BLANK=0, no slot SHALL be blanked.
REQ-019 Blanking SHALL be evaluated from the display register only, never from the pending register.

Reset
REQ-020 rst_n low SHALL asynchronously clear the prescaler, scan index, display register, pending register, and pending flag to 0.
REQ-021 During reset, digit SHALL be 3'b000 and an_n SHALL be 6'b111111.
REQ-022 After rst_n rises, the first clk edge SHALL light slot 0 showing 0; reset asserted mid-frame or with pending=1 discards the pending value.

Structure
REQ-023 NUM_DIGITS=6, DIGIT_W=3 and PRODUCT_W=16 SHALL live in the shared multiplier package with the other display constants.
REQ-024 The prescaler SHALL be a separate sub-module, scan_prescaler, with parameter REFRESH_DIV and outputs tick and count.
REQ-025 Digit extraction and blanking SHALL be combinational inside octal_display_scan, with registered outputs only.

Verification (REFRESH_DIV=4 unless noted)
REQ-026 Reset release with no strobe -> an_n cycles 111110 only (slots 1..5 blanked), digit=0, one slot step every 4 clk.
REQ-027 product_valid with product=16'hFFFF mid-frame -> pending=1 until the 5->0 wrap; the next frame shows digits 7,7,7,7,7,1 on slots 0..5, all lit.
REQ-028 product=16'd83 (octal 123) -> slots 0..2 show 3,2,1; slots 3..5 blanked. With LZ_BLANK=0, slots 3..5 lit showing 0.
REQ-029 Strobes with 16'd8 and then 16'd9 in the same frame -> only 9 (octal 11) is displayed; pending clears at the wrap.
REQ-030 Strobe 16'd7 on the exact commit-tick cycle -> the display shows 7 in the following frame and pending stays 0.
REQ-031 rst_n pulsed low while pending=1 and in slot 3 -> outputs go to digit=0 and an_n=111111 immediately, and the old pending value is never displayed.
